flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
- Shares one SPI flash read engine between two requesters (requester 0: DSP power dumper sample/coefficient fetch; requester 1: config/boot loader).
- Sits between the requesters and the flash reader's address/read handshake: arbitrates round-robin, sequences one read at a time, routes the 32-bit result back and acknowledges the reader.
- Adds a watchdog so a hung flash access cannot lock out both requesters.

Parameters:
- ADDR_W, 24, flash byte address width.
- DATA_W, 32, read word width.
- TIMEOUT_CYCLES, 4096, max clk cycles in WAIT_DATA before abort; legal range 16..2^20-1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- req_valid  in  2  per-requester read request, held until accepted.
- req_addr0  in  ADDR_W  requester 0 address.
- req_addr1  in  ADDR_W  requester 1 address.
- req_ready  out  2  one-cycle accept pulse for the granted requester.
- rsp_valid  out  2  response valid, held until rsp_ready of the same bit.
- rsp_ready  in  2  requester consumes response.
- rsp_data  out  DATA_W  response word, shared by both requesters; qualified by rsp_valid.
- rsp_err  out  1  valid with rsp_valid: 1 = timeout abort, rsp_data = 32'hDEAD_BEEF.
- rdr_addr_free  in  1  reader can take an address.
- rdr_addr_en  out  1  one-cycle address strobe to reader.
- rdr_addr_data  out  ADDR_W  address to reader; stable from ISSUE until the transaction ends.
- rdr_data_available  in  1  reader result ready.
- rdr_data  in  DATA_W  reader result.
- rdr_ack  out  1  one-cycle acknowledge to reader.
- timeout_sticky  out  1  set on any abort; cleared only by reset.

Behaviour:
- Reset (async, reset==0): all outputs 0, state IDLE, rr_ptr=0 (requester 0 has priority), timer 0. Asserting reset mid-transaction abandons it with no rsp_valid and no rdr_ack.
- IDLE:
  - If only one req_valid bit is set, grant it. If both are set, grant bit rr_ptr.
  - In the grant cycle: pulse req_ready[g], latch the granted address into addr_reg and g into gnt, then go to ISSUE.
- ISSUE: wait for rdr_addr_free==1, then drive rdr_addr_en=1 for exactly one cycle with rdr_addr_data=addr_reg, clear the timer, go to WAIT_DATA.
- WAIT_DATA: timer increments each cycle.
  - On rdr_data_available==1: capture rdr_data into rsp_data, pulse rdr_ack for one cycle, set rsp_err=0, go to DELIVER.
  - If timer==TIMEOUT_CYCLES-1 and no data has arrived: rsp_data=32'hDEAD_BEEF, rsp_err=1, set timeout_sticky, go to DELIVER. No rdr_ack is issued.
  - If data_available and the timeout occur in the same cycle, data wins.
- DELIVER:
  - Assert rsp_valid[gnt] and hold rsp_data/rsp_err stable.
  - On rsp_ready[gnt]==1: drop rsp_valid, set rr_ptr=~gnt, go to IDLE. Earliest new grant is the cycle after.
  - rsp_ready on the non-granted bit is ignored.
- Latency: req_ready-to-rdr_addr_en is at least 1 cycle; rdr_data_available-to-rsp_valid is 1 cycle.
- Only one transaction is outstanding at any time. req_valid dropping after acceptance has no effect.
- The timer is wide enough for TIMEOUT_CYCLES and does not wrap before the compare.

Optional Feature:
- Macro: FLASH_READ_ARB_CACHE_EN.
- Enabled: a single-entry last-read cache (addr, data, valid).
  - In the grant cycle, if valid==1 and the latched address equals the cached addr, skip ISSUE/WAIT_DATA. rsp_valid follows 1 cycle after req_ready, with the cached data and rsp_err=0; no reader activity.
  - The cache updates on every successful reader completion.
  - Timeouts and reset invalidate the cache.
- Disabled: every request goes through the reader; no cache storage is synthesized.

Test Plan:
- Single read: req_valid=2'b01, addr0=24'h000100; reader returns 32'h12345678 after 40 cycles -> one rdr_addr_en with data 24'h000100, one rdr_ack, rsp_valid[0] with rsp_data 32'h12345678, rsp_err=0.
- Contention: both req_valid held for 4 transactions -> grant order 0,1,0,1. Each rdr_addr_data matches the granted address.
- Back-pressure: rsp_ready[1] held low 20 cycles -> rsp_valid[1] and rsp_data stable; no new req_ready until it is consumed.
- Timeout: TIMEOUT_CYCLES=16, reader never returns -> rsp_valid after 16 WAIT_DATA cycles, rsp_data 32'hDEAD_BEEF, rsp_err=1, timeout_sticky=1, no rdr_ack. The next request is serviced normally.
- Reset mid-op: drive reset=0 during WAIT_DATA -> all outputs 0 immediately (async). After release, requester 0 wins a tie.
- Cache (macro on): two consecutive reads of 24'h000200 -> only one rdr_addr_en. Second response arrives 1 cycle after req_ready with identical data.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash read engine between two requesters.
// Optional single-entry last-read cache: define FLASH_READ_ARB_CACHE_EN.
module flash_read_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rdr_addr_free,
  output logic              rdr_addr_en,
  output logic [ADDR_W-1:0] rdr_addr_data,
  input  logic              rdr_data_available,
  input  logic [DATA_W-1:0] rdr_data,
  output logic              rdr_ack,
  output logic              timeout_sticky
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;

  logic              any_req;
  logic              g;
  logic [ADDR_W-1:0] g_addr;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign any_req = |req_valid;

  always_comb begin
    g = 1'b0;
    unique case (req_valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = rr_q;
      default: g = 1'b0;
    endcase
  end

  assign g_addr = g ? req_addr1 : req_addr0;

`ifdef FLASH_READ_ARB_CACHE_EN
  logic              c_valid_q;
  logic [ADDR_W-1:0] c_addr_q;
  logic [DATA_W-1:0] c_data_q;
  logic              c_fill;
  logic              c_inval;

  assign c_fill  = (state_q == WAIT_DATA) && rdr_data_available;
  assign c_inval = (state_q == WAIT_DATA) && !rdr_data_available
                   && (timer_q == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_valid_q <= 1'b0;
      c_addr_q  <= '0;
      c_data_q  <= '0;
    end else if (c_inval) begin
      c_valid_q <= 1'b0;
    end else if (c_fill) begin
      c_valid_q <= 1'b1;
      c_addr_q  <= addr_q;
      c_data_q  <= rdr_data;
    end
  end

  assign hit      = c_valid_q && (c_addr_q == g_addr);
  assign hit_data = c_data_q;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    data_d      = data_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rdr_addr_en = 1'b0;
    rdr_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset gate keeps the combinational grant quiet while held in reset
        if (any_req && reset) begin
          req_ready[g] = 1'b1;
          gnt_d        = g;
          addr_d       = g_addr;
          if (hit) begin
            data_d  = hit_data;
            err_d   = 1'b0;
            state_d = DELIVER;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rdr_addr_free) begin
          rdr_addr_en = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        timer_d = timer_q + 1'b1;
        if (rdr_data_available) begin
          data_d  = rdr_data;
          err_d   = 1'b0;
          rdr_ack = 1'b1;
          state_d = DELIVER;
        end else if (timer_q == T_LAST) begin
          data_d   = ABORT_WORD;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = DELIVER;
        end
      end
      DELIVER: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          rr_d    = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp_data       = data_q;
  assign rsp_err        = err_q;
  assign rdr_addr_data  = addr_q;
  assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a small behavioural flash reader.
// Cache checks follow FLASH_READ_ARB_CACHE_EN.
module tb_flash_read_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = '0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rdr_addr_free = 1'b1;
  logic          rdr_addr_en;
  logic [AW-1:0] rdr_addr_data;
  logic          rdr_data_available = 1'b0;
  logic [DW-1:0] rdr_data = '0;
  logic          rdr_ack;
  logic          timeout_sticky;

  always #5 clk = ~clk;

  flash_read_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr0(req_addr0),
    .req_addr1(req_addr1),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .rdr_addr_free(rdr_addr_free),
    .rdr_addr_en(rdr_addr_en),
    .rdr_addr_data(rdr_addr_data),
    .rdr_data_available(rdr_data_available),
    .rdr_data(rdr_data),
    .rdr_ack(rdr_ack),
    .timeout_sticky(timeout_sticky)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int            n_en = 0;
  int            n_ack = 0;
  logic [AW-1:0] en_addr = '0;

  always @(posedge rdr_addr_en) begin
    n_en++;
    en_addr = rdr_addr_data;
  end

  always @(posedge rdr_ack) n_ack++;

  // reader: answers lat negedges after the address strobe, unless hung
  int            lat = 3;
  logic          hang = 1'b0;
  logic [DW-1:0] rd_word = '0;
  logic          busy = 1'b0;
  int            wcnt = 0;

  always @(negedge clk) begin
    if (rdr_data_available) begin
      rdr_data_available = 1'b0;
      busy = 1'b0;
    end else if (rdr_addr_en && !hang) begin
      busy = 1'b1;
      wcnt = 1;
    end else if (busy) begin
      wcnt++;
      if (wcnt >= lat) begin
        rdr_data_available = 1'b1;
        rdr_data = rd_word;
      end
    end
    if (!reset) busy = 1'b0;
  end

  task automatic wait_grant(output logic [1:0] gr, output int ok);
    ok = 0;
    gr = '0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready != 2'b00) begin
        gr = req_ready;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int r, inout int cyc, output int ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid[r]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume(input int r);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  // one isolated read; cyc = negedges from acceptance to rsp_valid, plus one
  task automatic read1(input int r, input logic [AW-1:0] a,
                       input string tag, output int cyc,
                       output logic [DW-1:0] d, output logic e);
    logic [1:0] gr;
    int         ok;
    if (r == 0) req_addr0 = a;
    else        req_addr1 = a;
    req_valid[r] = 1'b1;
    wait_grant(gr, ok);
    check({tag, "_grant"}, gr, (r == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    req_valid[r] = 1'b0;
    cyc = 1;
    wait_rsp(r, cyc, ok);
    check({tag, "_rsp_seen"}, ok, 1);
    d = rsp_data;
    e = rsp_err;
    consume(r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]    gr;
    int            ok;
    int            cyc;
    int            en0;
    int            ack0;
    int            bad;
    logic [DW-1:0] d;
    logic          e;
    logic [AW-1:0] ca [2];

    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_data, rsp_err, rdr_addr_en,
           rdr_addr_data, rdr_ack, timeout_sticky}, 64'h0);
    req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);

    // contention: both held, expect 0,1,0,1
    ca[0] = 24'h0A0000;
    ca[1] = 24'h0B0000;
    req_addr0 = ca[0];
    req_addr1 = ca[1];
    lat = 3;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rd_word = 32'hC0DE_0000 + i;
      wait_grant(gr, ok);
      check($sformatf("cont_grant%0d", i), gr, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc = 0;
      wait_rsp(i % 2, cyc, ok);
      check($sformatf("cont_addr%0d", i), en_addr, ca[i % 2]);
      check($sformatf("cont_data%0d", i), rsp_data, 32'hC0DE_0000 + i);
      consume(i % 2);
    end
    req_valid = 2'b00;
    @(negedge clk);

    // back-pressure on requester 1
    rd_word = 32'h0BAD_F00D;
    req_addr1 = 24'h0C0000;
    req_valid[1] = 1'b1;
    wait_grant(gr, ok);
    @(negedge clk);
    req_valid[1] = 1'b0;
    cyc = 0;
    wait_rsp(1, cyc, ok);
    req_addr0 = 24'h0D0000;
    req_valid[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      rsp_ready[0] = (i == 5);
      if (rsp_valid !== 2'b10 || rsp_data !== 32'h0BAD_F00D ||
          req_ready !== 2'b00)
        bad++;
      @(negedge clk);
    end
    rsp_ready[0] = 1'b0;
    check("bp_stable", bad, 0);
    consume(1);
    wait_grant(gr, ok);
    check("bp_next_grant", gr, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    cyc = 0;
    wait_rsp(0, cyc, ok);
    check("bp_next_addr", en_addr, 24'h0D0000);
    consume(0);

    // single read, 40-cycle reader
    lat = 40;
    rd_word = 32'h1234_5678;
    en0 = n_en;
    ack0 = n_ack;
    read1(0, 24'h000100, "single", cyc, d, e);
    check("single_data", d, 32'h1234_5678);
    check("single_err", e, 1'b0);
    check("single_addr", en_addr, 24'h000100);
    check("single_n_en", n_en - en0, 1);
    check("single_n_ack", n_ack - ack0, 1);
    check("single_latency", cyc, 41);

    // timeout
    hang = 1'b1;
    ack0 = n_ack;
    read1(0, 24'h000300, "tmo", cyc, d, e);
    check("tmo_data", d, 32'hDEAD_BEEF);
    check("tmo_err", e, 1'b1);
    check("tmo_sticky", timeout_sticky, 1'b1);
    check("tmo_latency", cyc, TO + 2);
    check("tmo_no_ack", n_ack - ack0, 0);
    hang = 1'b0;
    lat = 4;
    rd_word = 32'h55AA_33CC;
    read1(0, 24'h000400, "post_tmo", cyc, d, e);
    check("post_tmo_data", d, 32'h55AA_33CC);
    check("post_tmo_err", e, 1'b0);
    check("post_tmo_latency", cyc, 5);

    // async reset during WAIT_DATA; round-robin pointer now favours 1
    hang = 1'b1;
    ack0 = n_ack;
    req_addr0 = 24'h000500;
    req_valid = 2'b01;
    wait_grant(gr, ok);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    req_addr1 = 24'h000600;
    req_valid = 2'b11;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outputs",
          {req_ready, rsp_valid, rsp_data, rsp_err, rdr_addr_en,
           rdr_addr_data, rdr_ack, timeout_sticky}, 64'h0);
    hang = 1'b0;
    @(negedge clk);
    check("rst_mid_no_ack", n_ack - ack0, 0);
    reset = 1'b1;
    wait_grant(gr, ok);
    check("rst_tie_grant0", gr, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    rd_word = 32'h0000_0500;
    cyc = 0;
    wait_rsp(0, cyc, ok);
    check("rst_after_data", rsp_data, 32'h0000_0500);
    consume(0);

    // repeated address
    lat = 5;
    rd_word = 32'hCAFE_F00D;
    en0 = n_en;
    read1(0, 24'h000200, "rep1", cyc, d, e);
    check("rep1_data", d, 32'hCAFE_F00D);
    read1(0, 24'h000200, "rep2", cyc, d, e);
    check("rep2_data", d, 32'hCAFE_F00D);
    check("rep2_err", e, 1'b0);
`ifdef FLASH_READ_ARB_CACHE_EN
    check("rep_n_en", n_en - en0, 1);
    check("rep2_latency", cyc, 1);
`else
    check("rep_n_en", n_en - en0, 2);
    check("rep2_latency", cyc, 6);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
